// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// overflow/underflow pulses and selectable standard / first-word-fall-through reads.
module sync_fifo_flags #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = 12,
  parameter int unsigned AE_THRESH = 4,
  parameter int unsigned FWFT      = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     wr_en,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_C    = PW'(AE_THRESH);

  if (WIDTH < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      AF_THRESH < 1 || AF_THRESH > DEPTH || AE_THRESH > DEPTH - 1 || FWFT > 1)
  begin : g_bad_params
    $error("sync_fifo_flags: illegal parameter combination");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic             r_overflow;
  logic             r_underflow;

  logic [PW-1:0]    w_count;
  logic             w_wr_acc;
  logic             w_rd_acc;

  // Occupancy is the wrap-bit pointer difference: a pure function of registered
  // pointers, so it steps exactly like an up/down counter with no input path.
  assign w_count      = r_wr_ptr - r_rd_ptr;
  assign count        = w_count;
  assign full         = (w_count == DEPTH_C);
  assign empty        = (w_count == '0);
  assign almost_full  = (w_count >= AF_C);
  assign almost_empty = (w_count <= AE_C);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  assign w_wr_acc = wr_en & ~full;
  assign w_rd_acc = rd_en & ~empty;

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr[AW-1:0]] <= data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_overflow  <= wr_en & full;
      r_underflow <= rd_en & empty;
    end
  end

  if (FWFT == 0) begin : g_std_read
    logic [WIDTH-1:0] r_data_out;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_data_out <= '0;
      end else if (w_rd_acc) begin
        r_data_out <= r_mem[r_rd_ptr[AW-1:0]];
      end
    end

    assign data_out = r_data_out;
  end else begin : g_fwft_read
    assign data_out = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboard bench for sync_fifo_flags: one standard-read and one FWFT instance,
// directed stimulus pushes expected post-edge state, a negedge monitor compares.
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic [7:0] din0 = '0, dout0;
  logic       wr0 = 1'b0, rd0 = 1'b0;
  logic       full0, empty0, af0, ae0, ovf0, unf0;
  logic [4:0] cnt0;

  logic [7:0] din1 = '0, dout1;
  logic       wr1 = 1'b0, rd1 = 1'b0;
  logic       full1, empty1, af1, ae1, ovf1, unf1;
  logic [4:0] cnt1;

  always #5 clk = ~clk;

  sync_fifo_flags #(.WIDTH(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(4), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .data_in(din0), .wr_en(wr0), .rd_en(rd0), .data_out(dout0),
    .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(cnt0), .overflow(ovf0), .underflow(unf0));

  sync_fifo_flags #(.WIDTH(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(4), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .data_in(din1), .wr_en(wr1), .rd_en(rd1), .data_out(dout1),
    .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(cnt1), .overflow(ovf1), .underflow(unf1));

  typedef struct {
    int         id;
    int         tgt;
    bit         chk_data;
    logic [7:0] dout;
    int         cnt;
    bit         full, empty, af, ae, ovf, unf;
  } exp_t;

  exp_t       sb[$];
  exp_t       me;
  logic [7:0] mq[$];
  logic [7:0] exp_dout0 = '0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic exp_t mk(input int id, input int cnt, input bit ovf, input bit unf,
                              input bit chk_data, input logic [7:0] d);
    exp_t e;
    e.id = id; e.tgt = cyc + 1; e.chk_data = chk_data; e.dout = d; e.cnt = cnt;
    e.full = (cnt == 16); e.empty = (cnt == 0);
    e.af = (cnt >= 12); e.ae = (cnt <= 4);
    e.ovf = ovf; e.unf = unf;
    return e;
  endfunction

  // Monitor: compares each record at the first negedge after its edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].tgt <= cyc) begin
      me = sb.pop_front();
      if (me.id == 0) begin
        chk("count0", 32'(cnt0), 32'(me.cnt));
        chk("full0", 32'(full0), 32'(me.full));
        chk("empty0", 32'(empty0), 32'(me.empty));
        chk("almost_full0", 32'(af0), 32'(me.af));
        chk("almost_empty0", 32'(ae0), 32'(me.ae));
        chk("overflow0", 32'(ovf0), 32'(me.ovf));
        chk("underflow0", 32'(unf0), 32'(me.unf));
        if (me.chk_data) chk("data_out0", 32'(dout0), 32'(me.dout));
      end else begin
        chk("count1", 32'(cnt1), 32'(me.cnt));
        chk("full1", 32'(full1), 32'(me.full));
        chk("empty1", 32'(empty1), 32'(me.empty));
        chk("almost_full1", 32'(af1), 32'(me.af));
        chk("almost_empty1", 32'(ae1), 32'(me.ae));
        chk("overflow1", 32'(ovf1), 32'(me.ovf));
        chk("underflow1", 32'(unf1), 32'(me.unf));
        if (me.chk_data) chk("data_out1", 32'(dout1), 32'(me.dout));
      end
    end
  end

  // Standard-mode step with a reference queue computing the expected outcome.
  task automatic step0(input bit w, input bit r, input logic [7:0] d);
    bit ovf, unf, wa, ra;
    @(negedge clk);
    wr0 = w; rd0 = r; din0 = d;
    wa  = w && (mq.size() < 16);
    ra  = r && (mq.size() > 0);
    ovf = w && (mq.size() == 16);
    unf = r && (mq.size() == 0);
    if (ra) exp_dout0 = mq.pop_front();
    if (wa) mq.push_back(d);
    sb.push_back(mk(0, mq.size(), ovf, unf, 1'b1, exp_dout0));
    @(posedge clk);
    #1;
    wr0 = 1'b0; rd0 = 1'b0;
  endtask

  // FWFT step with hand-computed expectations.
  task automatic step1(input bit w, input bit r, input logic [7:0] d, input int cnt,
                       input bit ovf, input bit unf, input bit chk_data, input logic [7:0] dx);
    @(negedge clk);
    wr1 = w; rd1 = r; din1 = d;
    sb.push_back(mk(1, cnt, ovf, unf, chk_data, dx));
    @(posedge clk);
    #1;
    wr1 = 1'b0; rd1 = 1'b0;
  endtask

  task automatic chk_reset_now(input string tag);
    chk({tag, "_count"}, 32'(cnt0), 32'd0);
    chk({tag, "_empty"}, 32'(empty0), 32'd1);
    chk({tag, "_full"}, 32'(full0), 32'd0);
    chk({tag, "_almost_full"}, 32'(af0), 32'd0);
    chk({tag, "_almost_empty"}, 32'(ae0), 32'd1);
    chk({tag, "_overflow"}, 32'(ovf0), 32'd0);
    chk({tag, "_underflow"}, 32'(unf0), 32'd0);
    chk({tag, "_data_out"}, 32'(dout0), 32'd0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    chk_reset_now("reset");
    chk("reset_count1", 32'(cnt1), 32'd0);
    chk("reset_empty1", 32'(empty1), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // FWFT: word visible the cycle after its write, pop empties, extra read underflows
    step1(1'b1, 1'b0, 8'h5A, 1, 1'b0, 1'b0, 1'b1, 8'h5A);
    step1(1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b1, 8'h5A);
    step1(1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h00);
    step1(1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b0, 8'h00);
    step1(1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h00);

    // Fill, overflow, drain, underflow
    for (int i = 1; i <= 16; i++) step0(1'b1, 1'b0, 8'(i));
    step0(1'b1, 1'b0, 8'hAA);
    step0(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) step0(1'b0, 1'b1, 8'h00);
    step0(1'b0, 1'b1, 8'h00);
    step0(1'b0, 1'b0, 8'h00);

    // Wrap-around with simultaneous read and write at count 8
    for (int i = 0; i < 8; i++) step0(1'b1, 1'b0, 8'(8'h80 + i));
    for (int i = 0; i < 40; i++) step0(1'b1, 1'b1, 8'(i));
    step0(1'b1, 1'b0, 8'hC0);

    // Async reset between edges at count 9
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_reset_now("async_reset");
    mq.delete();
    exp_dout0 = '0;
    #1 rst = 1'b0;
    step0(1'b1, 1'b0, 8'h33);
    step0(1'b0, 1'b1, 8'h00);
    step0(1'b0, 1'b0, 8'h00);

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Parametrised single-clock FIFO, the successor to the team's basic synchronous FIFO. Adds an occupancy count, programmable almost-full/almost-empty thresholds, overflow/underflow error pulses, and a selectable first-word-fall-through (FWFT) read mode. It is used as the general buffering primitive between streaming blocks that share one clock.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of storage entries; power of two, >=2
AF_THRESH, 12, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH
AE_THRESH, 4, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1
FWFT, 0, read mode: 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous reset, active-high
data_in  in  WIDTH  write data
wr_en  in  1  write request
rd_en  in  1  read request (FWFT=0) / read acknowledge (FWFT=1)
data_out  out  WIDTH  read data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  one-cycle pulse: a write was attempted while full
underflow  out  1  one-cycle pulse: a read was attempted while empty

Behaviour:
- Reset (async, rst=1): pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, data_out=0 (FWFT=0). Memory contents are not cleared.
- Reset mid-operation: all state above returns to reset values immediately, without waiting for a clock edge. The first edge after rst deasserts behaves as an empty FIFO.
- Storage: DEPTH x WIDTH array. Read and write pointers are $clog2(DEPTH)+1 bits; the MSB is a wrap bit. Index = pointer low bits, so wrap-around is natural modulo DEPTH.
- Write accepted iff wr_en && !full. On acceptance, mem[wr_ptr] <= data_in and wr_ptr increments.
- Read accepted iff rd_en && !empty. On acceptance, rd_ptr increments.
- A write while full is dropped. There is no write-through-on-read when full, even with rd_en=1 and a read accepted in the same cycle.
- count next-state:
  - +1 on write-only acceptance
  - -1 on read-only acceptance
  - unchanged when both or neither are accepted
- All flags are derived from registered count and change on the same edge as count. There is no combinational path from wr_en/rd_en to any flag.
- Simultaneous accepted read and write with 0<count<DEPTH: both pointers advance, count and flags are unchanged.
- FWFT=0: data_out is a register loaded with mem[rd_ptr] on the edge of an accepted read, so data is valid the cycle after the edge (1-cycle latency). It holds its value otherwise, including when empty.
- FWFT=1: data_out = mem[rd_ptr] combinationally whenever empty=0. A word written into an empty FIFO appears on data_out the cycle after its write edge. rd_en pops the shown word. data_out is don't-care while empty.
- overflow: registered. It is 1 for exactly the cycle after an edge where wr_en=1 && full=1, and 0 otherwise.
- underflow: the same rule for rd_en=1 && empty=1.
- Error events do not alter pointers, count, memory or data_out.
- Illegal parameter values are rejected at elaboration by a generate-time check.

Test Plan:
- Reset and fill: rst pulse, then 16 writes of 0x01..0x10 with DEPTH=16. Required: count steps 1..16; almost_full rises on the edge count reaches 12; full=1 after the 16th write; no overflow.
- Overflow: with the FIFO full, wr_en=1 with data 0xAA for 1 cycle. Required: overflow=1 for exactly one cycle, count stays 16, and later reads never return 0xAA.
- Drain and underflow (FWFT=0): 16 reads. Required: data_out=0x01..0x10 in order, each one cycle after its rd_en edge; almost_empty rises when count reaches 4; empty=1 at the end. An extra read gives underflow=1 for one cycle and data_out holds 0x10.
- Wrap-around with simultaneous read/write: preload 8 words, then 40 cycles of wr_en=rd_en=1 with an incrementing pattern. Required: count stays 8, flags are static, and output order is exactly the input order across pointer wrap.
- FWFT mode: with FWFT=1, write 0x5A into the empty FIFO. Required: data_out=0x5A the next cycle with rd_en=0; rd_en=1 for 1 cycle leaves empty=1 and count=0.
- Async reset mid-stream: assert rst between edges at count=9. Required: count=0, empty=1, full=0 immediately, before the next edge. After release, writing 0x33 then reading returns 0x33.
